dmem_wait_ctrl: RTL and testbench

Parametrised data memory with a valid/ready request port, configurable wait states, and byte/halfword/word access with sign or zero extension on loads. It replaces the single-cycle, word-only data RAM in the MEM stage of the pipelined CPU. The stall logic uses `req_ready` and `rsp_valid` to model a slow memory.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_lane_align.sv | 60 ++++++
 rtl/dmem_wait_ctrl.sv | 137 +++++++++++++
 tb/tb_dmem_wait_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the wait-state data memory: access sizes and controller states.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte mask and replicated data, load lane select
// with sign/zero extension, and the misalignment / reserved-size flag.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NB     = DATA_W / 8,
  parameter int OFS_W  = $clog2(NB)
) (
  input  logic [1:0]        size,
  input  logic [OFS_W-1:0]  offset,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              misalign
);

  logic [OFS_W-1:0]  off_h;
  logic [DATA_W-1:0] sh_b;
  logic [DATA_W-1:0] sh_h;

  always_comb begin
    off_h    = offset;
    off_h[0] = 1'b0;
    sh_b     = rword >> {offset, 3'b000};
    sh_h     = rword >> {off_h, 3'b000};
  end

  always_comb begin
    be        = '0;
    wdata_rep = wdata;
    rdata_ext = '0;
    misalign  = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = NB'(1) << offset;
        wdata_rep = {NB{wdata[7:0]}};
        rdata_ext = {{(DATA_W-8){sign_ext & sh_b[7]}}, sh_b[7:0]};
      end
      SZ_HALF: begin
        misalign  = offset[0];
        be        = NB'(3) << off_h;
        wdata_rep = {(NB/2){wdata[15:0]}};
        rdata_ext = {{(DATA_W-16){sign_ext & sh_h[15]}}, sh_h[15:0]};
      end
      SZ_WORD: begin
        misalign  = (offset != '0);
        be        = '1;
        rdata_ext = rword;
      end
      default: misalign = 1'b1;
    endcase
    // Any fault suppresses the write entirely.
    if (misalign) be = '0;
  end

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Data memory with valid/ready request port and a fixed number of wait states
// between acceptance and the array access; one registered response per request.
module dmem_wait_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter int WAIT_CYC   = 2,
  localparam int NB        = DATA_W / 8,
  localparam int OFS_W     = $clog2(NB),
  localparam int AW        = DEPTH_LOG2 + OFS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;

  logic              cap_we, cap_signed;
  logic [1:0]        cap_size;
  logic [AW-1:0]     cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  logic              op_we, op_signed;
  logic [1:0]        op_size;
  logic [AW-1:0]     op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              access;

  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata_rep, rdata_ext, rword;
  logic              misalign;

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2] = '{1: DATA_W'('hA), 2: DATA_W'('hB),
                                            3: DATA_W'('hC), 4: DATA_W'('hD),
                                            default: '0};

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    req_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_nx   = WAIT_LD;
          state_nx = (WAIT_CYC > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) state_nx = ST_RESP;
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge, so the
  // live request fields feed the array instead of the captured copy.
  always_comb begin
    if (state == ST_IDLE) begin
      op_we = req_we; op_size = req_size; op_signed = req_signed;
      op_addr = req_addr; op_wdata = req_wdata;
    end else begin
      op_we = cap_we; op_size = cap_size; op_signed = cap_signed;
      op_addr = cap_addr; op_wdata = cap_wdata;
    end
    access = rst_n && (state_nx == ST_RESP);
  end

  assign rword     = mem[op_addr[AW-1:OFS_W]];
  assign rsp_valid = (state == ST_RESP);

  dmem_lane_align #(.DATA_W(DATA_W), .NB(NB), .OFS_W(OFS_W)) u_align (
    .size      (op_size),
    .offset    (op_addr[OFS_W-1:0]),
    .sign_ext  (op_signed),
    .wdata     (op_wdata),
    .rword     (rword),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      cap_we     <= 1'b0;
      cap_size   <= '0;
      cap_signed <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == ST_IDLE && req_valid) begin
        cap_we     <= req_we;
        cap_size   <= req_size;
        cap_signed <= req_signed;
        cap_addr   <= req_addr;
        cap_wdata  <= req_wdata;
      end
      if (access) begin
        rsp_err   <= misalign;
        rsp_rdata <= (misalign || op_we) ? '0 : rdata_ext;
      end
    end
  end

  // Array has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (access && op_we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[op_addr[AW-1:OFS_W]][b*8 +: 8] <= wdata_rep[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Directed bench for dmem_wait_ctrl with DATA_W=32, DEPTH_LOG2=5, WAIT_CYC=2.
module tb_dmem_wait_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_wait_ctrl #(.DATA_W(32), .DEPTH_LOG2(5), .WAIT_CYC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request from IDLE; acceptance cycle is 0, response expected in cycle 3.
  task automatic access(input string tag, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [6:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    int n;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd3);
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_vld_lo"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_ready_again"}, 32'(req_ready), 32'd1);
    chk({tag, "_hold"}, rsp_rdata, exp_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout CHECKS %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);

    access("ld_w04", 1'b0, 2'd2, 1'b0, 7'h04, 32'h0, 32'h0000000A, 1'b0);

    access("st_b09", 1'b1, 2'd0, 1'b0, 7'h09, 32'h00000080, 32'h0, 1'b0);
    access("ld_sb09", 1'b0, 2'd0, 1'b1, 7'h09, 32'h0, 32'hFFFFFF80, 1'b0);
    access("ld_ub09", 1'b0, 2'd0, 1'b0, 7'h09, 32'h0, 32'h00000080, 1'b0);
    access("ld_w08", 1'b0, 2'd2, 1'b0, 7'h08, 32'h0, 32'h0000800B, 1'b0);
    access("ld_sh08", 1'b0, 2'd1, 1'b1, 7'h08, 32'h0, 32'hFFFF800B, 1'b0);

    access("st_h0e", 1'b1, 2'd1, 1'b0, 7'h0E, 32'h00001234, 32'h0, 1'b0);
    access("ld_w0c", 1'b0, 2'd2, 1'b0, 7'h0C, 32'h0, 32'h1234000C, 1'b0);
    access("ld_sh0e", 1'b0, 2'd1, 1'b1, 7'h0E, 32'h0, 32'h00001234, 1'b0);

    access("ld_w05_mis", 1'b0, 2'd2, 1'b0, 7'h05, 32'h0, 32'h0, 1'b1);
    access("st_w06_mis", 1'b1, 2'd2, 1'b0, 7'h06, 32'hDEADBEEF, 32'h0, 1'b1);
    access("ld_w04_after", 1'b0, 2'd2, 1'b0, 7'h04, 32'h0, 32'h0000000A, 1'b0);
    access("ld_h03_mis", 1'b0, 2'd1, 1'b0, 7'h03, 32'h0, 32'h0, 1'b1);
    access("ld_rsvd", 1'b0, 2'd3, 1'b0, 7'h04, 32'h0, 32'h0, 1'b1);

    // Back-to-back: valid held high for 12 cycles.
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 7'h04;
    req_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("bb_ready_%0d", i), 32'(req_ready), 32'((i % 4) == 0));
      chk($sformatf("bb_valid_%0d", i), 32'(rsp_valid), 32'((i % 4) == 3));
      if (req_ready && req_valid) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("bb_accepts", 32'(acc), 32'd3);
    chk("bb_rdata", rsp_rdata, 32'h0000000A);

    // Reset during WAIT drops a pending store.
    @(negedge clk);
    chk("rw_ready", 32'(req_ready), 32'd1);
    req_we = 1'b1; req_size = 2'd2; req_addr = 7'h10; req_wdata = 32'h00000055;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rw_valid_c2", 32'(rsp_valid), 32'd0);
    chk("rw_ready_rel", 32'(req_ready), 32'd1);
    chk("rw_rdata_clr", rsp_rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rw_novalid_%0d", i), 32'(rsp_valid), 32'd0);
    end
    access("ld_w10", 1'b0, 2'd2, 1'b0, 7'h10, 32'h0, 32'h0000000D, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
